// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI mode-0 peripheral that decodes 16-bit frames into the five PWM control registers.
// Optional read-back on cipo is enabled by defining the macro SPI_READBACK_EN.
module spi_reg_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       xfer_done,
  output logic       frame_err
);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, COMMIT} state_t;

  localparam int         NUM_REGS = 5;
  localparam logic [6:0] MAX_A    = 7'(MAX_ADDR);
  localparam logic [1:0] FLUSH_N  = 2'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
  logic                   sclk_d, ncs_d;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_rise, ncs_rise;
  logic [1:0]             flush_cnt;
  logic                   flush_done;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [15:0] shreg, sh_nxt;
  logic [7:0]  regs [NUM_REGS];

  logic       rw, len_ok, addr_ok, commit_ok, err;
  logic [6:0] addr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b1;
      flush_cnt <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sclk_d    <= sclk_s;
      ncs_d     <= ncs_s;
      if (flush_cnt != FLUSH_N) flush_cnt <= flush_cnt + 2'd1;
    end
  end

  assign sclk_s     = sclk_sync[SYNC_STAGES-1];
  assign copi_s     = copi_sync[SYNC_STAGES-1];
  assign ncs_s      = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_d;
  assign ncs_rise   = ncs_s & ~ncs_d;
  // The reset value of the ncs chain says nothing about the pin, so wait until it has been flushed.
  assign flush_done = (flush_cnt == FLUSH_N);

  assign sh_nxt  = {shreg[14:0], copi_s};
  assign rw      = shreg[15];
  assign addr    = shreg[14:8];
  assign len_ok  = (cnt == 5'd16);
  assign addr_ok = (addr <= MAX_A);
  assign err     = !len_ok || (rw && !addr_ok);
`ifdef SPI_READBACK_EN
  assign commit_ok = len_ok && addr_ok;
`else
  assign commit_ok = len_ok && rw && addr_ok;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next state gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_IDLE: if (flush_done && ncs_s) state_nxt = IDLE;
      // Level-sensitive start also catches a fall that lands during COMMIT after a one-cycle deselect.
      IDLE:      if (!ncs_s) state_nxt = SHIFT;
      SHIFT:     if (ncs_rise) state_nxt = COMMIT;
      COMMIT:    state_nxt = IDLE;
      default:   state_nxt = WAIT_IDLE;
    endcase
  end

  // NOTE: the register file is only five bytes and drives the PWM block directly, so it is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      shreg     <= '0;
      xfer_done <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      xfer_done <= (state == COMMIT) && commit_ok;
      frame_err <= (state == COMMIT) && err;
      if (state == IDLE) begin
        cnt   <= '0;
        shreg <= '0;
      end else if (state == SHIFT && sclk_rise) begin
        shreg <= sh_nxt;
        if (cnt != 5'd17) cnt <= cnt + 5'd1;
      end
      if (state == COMMIT && len_ok && rw && addr_ok) begin
        for (int i = 0; i < NUM_REGS; i++)
          if (addr == 7'(i)) regs[i] <= shreg[7:0];
      end
    end
  end

  assign en_reg_out_7_0  = regs[0];
  assign en_reg_out_15_8 = regs[1];
  assign en_reg_pwm_7_0  = regs[2];
  assign en_reg_pwm_15_8 = regs[3];
  assign pwm_duty_cycle  = regs[4];

`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic       rd_active;
  logic [7:0] tx_sh, rd_val;

  assign sclk_fall = ~sclk_s & sclk_d;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (sh_nxt[6:0] == 7'(i)) rd_val = regs[i];
  end

  // Loaded on the 8th rise; the fall right after it is skipped so bit 7 is held for the 9th rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_active <= 1'b0;
      tx_sh     <= '0;
    end else if (state != SHIFT) begin
      rd_active <= 1'b0;
      tx_sh     <= '0;
    end else if (sclk_rise && cnt == 5'd7) begin
      rd_active <= !sh_nxt[7] && (sh_nxt[6:0] <= MAX_A);
      tx_sh     <= rd_val;
    end else if (sclk_fall && cnt >= 5'd9 && cnt <= 5'd15) begin
      tx_sh <= {tx_sh[6:0], 1'b0};
    end
  end

  assign cipo = rd_active && (cnt >= 5'd8) && (cnt <= 5'd15) && tx_sh[7];
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: directed SPI frames, expected commits queued and checked by a monitor.
module tb_spi_reg_bridge;

  localparam int HALF = 4;  // sclk half-period in clk cycles

  typedef struct packed {
    logic        done;
    logic        err;
    logic [39:0] regs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, sclk, copi, ncs;
  logic       cipo, xfer_done, frame_err;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

  int         n_checks = 0;
  int         n_errors = 0;
  exp_t       sb[$];
  logic [7:0] mregs [5];
  logic [15:0] rx;
`ifdef SPI_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  spi_reg_bridge #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .xfer_done(xfer_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] dut_regs();
    return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
  endfunction

  function automatic logic [39:0] model_regs();
    return {mregs[4], mregs[3], mregs[2], mregs[1], mregs[0]};
  endfunction

  // Frame outcome model: push the expected pulse and register snapshot, if any.
  task automatic expect_frame(input logic [15:0] word, input int nbits);
    exp_t       e;
    logic [6:0] a;
    a = word[14:8];
    e.done = 1'b0;
    e.err  = 1'b0;
    if (nbits != 16) e.err = 1'b1;
    else if (word[15] && a <= 7'd4) begin
      mregs[a[2:0]] = word[7:0];
      e.done = 1'b1;
    end else if (word[15]) e.err = 1'b1;
    else if (READBACK && a <= 7'd4) e.done = 1'b1;
    e.regs = model_regs();
    if (e.done || e.err) sb.push_back(e);
  endtask

  task automatic spi_frame(input logic [15:0] word, input int nbits, input int hold,
                           output logic [15:0] rx_word);
    rx_word = '0;
    ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      copi = (i < 16) ? word[15-i] : 1'b0;
      repeat (HALF) @(negedge clk);
      if (i < 16) rx_word[15-i] = cipo;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    ncs = 1'b1;
    repeat (hold) @(negedge clk);
  endtask

  task automatic run_frame(input logic [15:0] word, input int nbits, input int hold);
    expect_frame(word, nbits);
    spi_frame(word, nbits, hold, rx);
  endtask

  task automatic wait_drain();
    int budget;
    budget = 40;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (xfer_done || frame_err)) begin
        if (sb.size() == 0) check("unexpected_pulse", {62'd0, xfer_done, frame_err}, 64'd0);
        else begin
          e = sb.pop_front();
          check("pulse_kind", {62'd0, xfer_done, frame_err}, {62'd0, e.done, e.err});
          check("regs_at_commit", {24'd0, dut_regs()}, {24'd0, e.regs});
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] w;
    for (int i = 0; i < 5; i++) mregs[i] = 8'h00;
    rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;

    // Reset with random pin activity
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sclk = 1'($urandom_range(0, 1));
      copi = 1'($urandom_range(0, 1));
      ncs  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("reset_regs", {24'd0, dut_regs()}, 64'd0);
      check("reset_cipo", {63'd0, cipo}, 64'd0);
      check("reset_pulses", {62'd0, xfer_done, frame_err}, 64'd0);
    end

    // Reset released mid-frame: the rest of the write frame must be ignored
    sclk = 1'b0; ncs = 1'b0;
    w = 16'h80AA;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      copi = w[15-i];
      if (i == 3) rst = 1'b0;
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    ncs = 1'b1;
    repeat (12) @(negedge clk);
    check("midframe_release_regs", {24'd0, dut_regs()}, 64'd0);

    // Single writes
    run_frame(16'h80F0, 16, 8);
    wait_drain();
    check("write_reg0", {56'd0, en_reg_out_7_0}, 64'hF0);
    run_frame(16'h8480, 16, 8);
    wait_drain();
    check("write_duty", {56'd0, pwm_duty_cycle}, 64'h80);

    // Back-to-back writes, ncs high for a single clk between frames
    run_frame(16'h81AA, 16, 1);
    run_frame(16'h8255, 16, 1);
    run_frame(16'h83CC, 16, 8);
    wait_drain();
    check("b2b_regs", {24'd0, dut_regs()}, 64'h80_CC_55_AA_F0);

    // Bad frame lengths
    run_frame(16'h8011, 15, 8);
    wait_drain();
    run_frame(16'h8011, 17, 8);
    wait_drain();
    check("badlen_reg0", {56'd0, en_reg_out_7_0}, 64'hF0);

    // Invalid addresses
    run_frame(16'h857F, 16, 8);
    wait_drain();
    run_frame(16'hFF00, 16, 8);
    wait_drain();
    check("badaddr_regs", {24'd0, dut_regs()}, 64'h80_CC_55_AA_F0);

    // Write then read back
    run_frame(16'h843C, 16, 8);
    wait_drain();
    run_frame(16'h0400, 16, 8);
    wait_drain();
    check("read_cipo", {48'd0, rx}, READBACK ? 64'h003C : 64'h0000);
    check("read_keeps_duty", {56'd0, pwm_duty_cycle}, 64'h3C);

    repeat (10) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
